// File: rtl/iterative_divider.sv
// rtl/iterative_divider.sv - restoring shift-and-subtract divider for MIPS DIV/DIVU
// One quotient bit per cycle; signs are stripped on launch and reapplied in FIX.
module iterative_divider #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);
   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] q_q, q_d, r_q, r_d, d_q, d_d, dvd_q, dvd_d;
   logic [WIDTH-1:0] quo_q, quo_d, rem_q, rem_d;
   logic             neg_q_q, neg_q_d, neg_r_q, neg_r_d, dz_q, dz_d;
   logic             dbz_q, dbz_d, done_q, done_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   logic [WIDTH:0]   shifted, diff;
   logic [WIDTH-1:0] mag_a, mag_b, q_fix, r_fix;

   always_comb begin
      state_d = state_q;
      q_d     = q_q;
      r_d     = r_q;
      d_d     = d_q;
      dvd_d   = dvd_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      neg_q_d = neg_q_q;
      neg_r_d = neg_r_q;
      dz_d    = dz_q;
      dbz_d   = dbz_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;

      mag_a = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
      mag_b = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;
      // Partial remainder keeps its top bit so divisors above 2^(WIDTH-1) still work.
      shifted = {r_q, q_q[WIDTH-1]};
      diff    = shifted - {1'b0, d_q};
      q_fix   = neg_q_q ? -q_q : q_q;
      r_fix   = neg_r_q ? -r_q : r_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               q_d     = mag_a;
               d_d     = mag_b;
               r_d     = '0;
               dvd_d   = dividend;
               neg_q_d = is_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
               neg_r_d = is_signed && dividend[WIDTH-1];
               dz_d    = (divisor == '0);
               cnt_d   = CW'(WIDTH);
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (!diff[WIDTH]) begin
               r_d = diff[WIDTH-1:0];
               q_d = {q_q[WIDTH-2:0], 1'b1};
            end else begin
               r_d = shifted[WIDTH-1:0];
               q_d = {q_q[WIDTH-2:0], 1'b0};
            end
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CW'(1)) state_d = S_FIX;
         end
         S_FIX: begin
            quo_d   = dz_q ? '1 : q_fix;
            rem_d   = dz_q ? dvd_q : r_fix;
            dbz_d   = dz_q;
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         q_q     <= '0;
         r_q     <= '0;
         d_q     <= '0;
         dvd_q   <= '0;
         quo_q   <= '0;
         rem_q   <= '0;
         neg_q_q <= 1'b0;
         neg_r_q <= 1'b0;
         dz_q    <= 1'b0;
         dbz_q   <= 1'b0;
         done_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         q_q     <= q_d;
         r_q     <= r_d;
         d_q     <= d_d;
         dvd_q   <= dvd_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         neg_q_q <= neg_q_d;
         neg_r_q <= neg_r_d;
         dz_q    <= dz_d;
         dbz_q   <= dbz_d;
         done_q  <= done_d;
         cnt_q   <= cnt_d;
      end
   end

   assign busy        = (state_q != S_IDLE);
   assign done        = done_q;
   assign quotient    = quo_q;
   assign remainder   = rem_q;
   assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_iterative_divider.sv
// tb/tb_iterative_divider.sv - self-checking bench for iterative_divider
// Expected results come from native 64-bit arithmetic; timing from a fixed-latency queue.
module tb_iterative_divider;
   localparam int W = 32;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic          is_signed = 1'b0;
   logic [W-1:0]  dividend = '0;
   logic [W-1:0]  divisor = '0;
   logic          busy, done, div_by_zero;
   logic [W-1:0]  quotient, remainder;

   int n_checks = 0;
   int n_fail = 0;
   int cyc = 0;

   typedef struct {
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         dz;
      int           c0;
      int           cd;
   } exp_t;
   exp_t expq[$];

   iterative_divider #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .start(start), .is_signed(is_signed),
      .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
      .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sg,
                        output logic [W-1:0] q, output logic [W-1:0] r, output logic dz);
      longint sa, sb, lq, lr;
      if (b == 0) begin
         q = '1; r = a; dz = 1'b1;
      end else if (sg) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         lq = sa / sb;
         lr = sa % sb;
         q = lq[W-1:0]; r = lr[W-1:0]; dz = 1'b0;
      end else begin
         q = a / b; r = a % b; dz = 1'b0;
      end
   endtask

   task automatic pin(input logic [W-1:0] a, input logic [W-1:0] b, input logic sg,
                      input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz);
      logic [W-1:0] q, r;
      logic dz;
      model(a, b, sg, q, r, dz);
      chk("model_q", q, eq);
      chk("model_r", r, er);
      chk("model_dz", {31'b0, dz}, {31'b0, edz});
   endtask

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sg);
      exp_t e;
      int k;
      k = 0;
      while (busy && k < 100) begin
         @(negedge clk);
         k++;
      end
      chk("idle_before_start", {31'b0, busy}, 32'd0);
      dividend = a; divisor = b; is_signed = sg; start = 1'b1;
      model(a, b, sg, e.q, e.r, e.dz);
      e.c0 = cyc + 1;
      e.cd = cyc + 1 + W + 1;
      expq.push_back(e);
      @(negedge clk);
      start = 1'b0;
      dividend = $urandom; divisor = $urandom; is_signed = $urandom_range(0, 1);
   endtask

   // Compare process: samples 1 time unit after every rising edge.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (!reset) begin
            if (expq.size() > 0 && cyc == expq[0].cd) begin
               chk("done_pulse", {31'b0, done}, 32'd1);
               chk("busy_at_done", {31'b0, busy}, 32'd0);
               chk("quotient", quotient, expq[0].q);
               chk("remainder", remainder, expq[0].r);
               chk("div_by_zero", {31'b0, div_by_zero}, {31'b0, expq[0].dz});
               void'(expq.pop_front());
            end else begin
               chk("no_done", {31'b0, done}, 32'd0);
               chk("busy", {31'b0, busy},
                   {31'b0, (expq.size() > 0 && cyc >= expq[0].c0 && cyc < expq[0].cd)});
            end
         end
      end
   end

   initial begin
      int k;
      logic [W-1:0] ra, rb;

      pin(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0);
      pin(32'hFFFFFFF9, 32'd2, 1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0);
      pin(32'd7, 32'hFFFFFFFE, 1'b1, 32'hFFFFFFFD, 32'd1, 1'b0);
      pin(32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'd0, 1'b0);
      pin(32'h12345678, 32'd0, 1'b1, 32'hFFFFFFFF, 32'h12345678, 1'b1);
      pin(32'd1000, 32'd3, 1'b0, 32'd333, 32'd1, 1'b0);

      repeat (3) @(negedge clk);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_done", {31'b0, done}, 32'd0);
      chk("rst_quotient", quotient, 32'd0);
      chk("rst_remainder", remainder, 32'd0);
      chk("rst_dbz", {31'b0, div_by_zero}, 32'd0);
      reset = 1'b0;
      @(negedge clk);

      run_op(32'd100, 32'd7, 1'b0);
      run_op(32'hFFFFFFF9, 32'd2, 1'b1);
      run_op(32'd7, 32'hFFFFFFFE, 1'b1);
      run_op(32'h80000000, 32'hFFFFFFFF, 1'b1);
      run_op(32'hFFFFFFFF, 32'd1, 1'b0);
      run_op(32'h12345678, 32'd0, 1'b0);
      run_op(32'h12345678, 32'd0, 1'b1);
      run_op(32'hFFFFFFFF, 32'h80000001, 1'b0);

      run_op(32'd1000, 32'd3, 1'b0);
      repeat (9) @(negedge clk);
      dividend = 32'd9; divisor = 32'd4; is_signed = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      run_op(32'd50, 32'd7, 1'b0);

      run_op(32'hDEADBEEF, 32'd3, 1'b0);
      repeat (15) @(negedge clk);
      reset = 1'b1;
      expq.delete();
      @(negedge clk);
      reset = 1'b0;
      chk("abort_busy", {31'b0, busy}, 32'd0);
      chk("abort_done", {31'b0, done}, 32'd0);
      chk("abort_quotient", quotient, 32'd0);
      chk("abort_remainder", remainder, 32'd0);
      chk("abort_dbz", {31'b0, div_by_zero}, 32'd0);
      repeat (40) @(negedge clk);
      run_op(32'd50, 32'd5, 1'b0);

      for (int i = 0; i < 30; i++) begin
         ra = $urandom;
         case (i % 5)
            0: rb = $urandom_range(1, 15);
            1: rb = -$urandom_range(1, 15);
            2: rb = (i % 10 == 2) ? 32'd0 : $urandom;
            default: rb = $urandom;
         endcase
         run_op(ra, rb, i[0]);
      end

      k = 0;
      while (expq.size() > 0 && k < 200) begin
         @(negedge clk);
         k++;
      end
      chk("all_results_seen", expq.size(), 32'd0);
      repeat (5) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
